// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: state encoding, NOP encoding, PC width and RV32 opcodes.
package fetch_pkg;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned CNT_W   = 8;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

   // Major opcodes shared with control/decode
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC computation: sequential pc+4 or JALR-style target with bit0 cleared and bit1 alignment check.
module fetch_next_pc
   import fetch_pkg::*;
(
   input  logic [PC_W-1:0] pc_i,
   input  logic            pc_sel_i,
   input  logic [PC_W-1:0] branch_target_i,
   output logic [PC_W-1:0] pc_plus4_o,
   output logic [PC_W-1:0] next_pc_o,
   output logic            misaligned_o
);

   logic [PC_W-1:0] eff_target;

   always_comb begin
      pc_plus4_o   = pc_i + PC_W'(4);
      eff_target   = {branch_target_i[PC_W-1:1], 1'b0};
      misaligned_o = pc_sel_i & eff_target[1];
      // A misaligned target leaves the PC where it is
      if (!pc_sel_i)        next_pc_o = pc_plus4_o;
      else if (misaligned_o) next_pc_o = pc_i;
      else                  next_pc_o = eff_target;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, issues single-beat imem reads with req/ack and timeout.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_start,
   input  logic        pc_update,
   input  logic        pc_sel,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        busy,
   output logic        fault
);

   fetch_state_e      state_q;
   logic [PC_W-1:0]   pc_q;
   logic [PC_W-1:0]   imem_addr_q;
   logic [INSTR_W-1:0] instr_q;
   logic              instr_valid_q;
   logic              imem_req_q;
   logic              fault_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              pend_vld_q;
   logic              pend_sel_q;
   logic [PC_W-1:0]   pend_tgt_q;

   logic              upd_vld_d;
   logic              upd_sel_d;
   logic [PC_W-1:0]   upd_tgt_d;
   logic [PC_W-1:0]   next_pc_d;
   logic              misaligned_d;

   // A live pc_update takes precedence over the one captured earlier in REQ
   always_comb begin
      upd_vld_d = pc_update | pend_vld_q;
      upd_sel_d = pc_update ? pc_sel : pend_sel_q;
      upd_tgt_d = pc_update ? branch_target : pend_tgt_q;
   end

   fetch_next_pc u_next_pc (
      .pc_i            (pc_q),
      .pc_sel_i        (upd_sel_d),
      .branch_target_i (upd_tgt_d),
      .pc_plus4_o      (pc_plus4),
      .next_pc_o       (next_pc_d),
      .misaligned_o    (misaligned_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         imem_addr_q   <= RESET_PC;
         instr_q       <= NOP_WORD;
         instr_valid_q <= 1'b0;
         imem_req_q    <= 1'b0;
         fault_q       <= 1'b0;
         cnt_q         <= '0;
         pend_vld_q    <= 1'b0;
         pend_sel_q    <= 1'b0;
         pend_tgt_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pc_update && misaligned_d) begin
                  fault_q <= 1'b1;
                  state_q <= ST_FAULT;
               end else begin
                  if (pc_update) pc_q <= next_pc_d;
                  if (fetch_start) begin
                     state_q       <= ST_REQ;
                     imem_req_q    <= 1'b1;
                     imem_addr_q   <= pc_update ? next_pc_d : pc_q;
                     instr_valid_q <= 1'b0;
                     cnt_q         <= '0;
                  end
               end
            end
            ST_REQ: begin
               if (imem_ack || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  imem_req_q <= 1'b0;
                  pend_vld_q <= 1'b0;
                  if (imem_ack) begin
                     instr_q       <= imem_rdata;
                     instr_valid_q <= 1'b1;
                     state_q       <= ST_IDLE;
                  end else begin
                     instr_q       <= NOP_WORD;
                     instr_valid_q <= 1'b0;
                     fault_q       <= 1'b1;
                     state_q       <= ST_FAULT;
                  end
                  // Deferred PC update is committed on the edge leaving REQ
                  if (upd_vld_d) begin
                     if (misaligned_d) begin
                        fault_q <= 1'b1;
                        state_q <= ST_FAULT;
                     end else begin
                        pc_q <= next_pc_d;
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (pc_update) begin
                     pend_vld_q <= 1'b1;
                     pend_sel_q <= pc_sel;
                     pend_tgt_q <= branch_target;
                  end
               end
            end
            ST_FAULT: begin
               imem_req_q <= 1'b0;
            end
            default: begin
               state_q    <= ST_FAULT;
               fault_q    <= 1'b1;
               imem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = imem_addr_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign busy        = (state_q == ST_REQ);
   assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_start;
   logic        pc_update;
   logic        pc_sel;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        busy;
   logic        fault;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_start   (fetch_start),
      .pc_update     (pc_update),
      .pc_sel        (pc_sel),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ack      (imem_ack),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .busy          (busy),
      .fault         (fault)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse_update(input logic sel, input logic [31:0] tgt);
      pc_update = 1'b1; pc_sel = sel; branch_target = tgt;
      step();
      pc_update = 1'b0; pc_sel = 1'b0; branch_target = '0;
   endtask

   initial begin
      rst = 1'b1; fetch_start = 1'b0; pc_update = 1'b0; pc_sel = 1'b0;
      branch_target = '0; imem_rdata = '0; imem_ack = 1'b0;
      step(); step();
      rst = 1'b0;
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, NOP);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_plus4", pc_plus4, 32'h4);

      // Zero-wait fetch
      fetch_start = 1'b1; step(); fetch_start = 1'b0;
      chk("f1_req", 32'(imem_req), 32'd1);
      chk("f1_addr", imem_addr, 32'h0);
      chk("f1_busy", 32'(busy), 32'd1);
      chk("f1_valid_low", 32'(instr_valid), 32'd0);
      imem_ack = 1'b1; imem_rdata = 32'h0050_0093; step(); imem_ack = 1'b0;
      chk("f1_instr", instr, 32'h0050_0093);
      chk("f1_valid", 32'(instr_valid), 32'd1);
      chk("f1_req_done", 32'(imem_req), 32'd0);
      chk("f1_pc", pc, 32'h0);

      // Sequential updates and wrap
      pulse_update(1'b0, '0); chk("seq_pc4", pc, 32'h4);  chk("seq_p4_8", pc_plus4, 32'h8);
      pulse_update(1'b0, '0); chk("seq_pc8", pc, 32'h8);  chk("seq_p4_12", pc_plus4, 32'hC);
      pulse_update(1'b0, '0); chk("seq_pc12", pc, 32'hC); chk("seq_p4_16", pc_plus4, 32'h10);
      pulse_update(1'b1, 32'hFFFF_FFFC);
      chk("top_pc", pc, 32'hFFFF_FFFC);
      chk("top_plus4", pc_plus4, 32'h0);
      pulse_update(1'b0, '0);
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_plus4", pc_plus4, 32'h4);
      chk("ir_kept", instr, 32'h0050_0093);
      chk("valid_kept", 32'(instr_valid), 32'd1);

      // Branch with bit0 set, then misaligned target
      pulse_update(1'b1, 32'h0000_0101);
      chk("br_pc", pc, 32'h100);
      chk("br_fault", 32'(fault), 32'd0);
      pulse_update(1'b1, 32'h0000_0102);
      chk("mis_pc", pc, 32'h100);
      chk("mis_fault", 32'(fault), 32'd1);
      fetch_start = 1'b1; step(); fetch_start = 1'b0; step();
      chk("mis_noreq", 32'(imem_req), 32'd0);
      chk("mis_nobusy", 32'(busy), 32'd0);
      rst = 1'b1; step(); rst = 1'b0;
      chk("clr_fault", 32'(fault), 32'd0);
      chk("clr_pc", pc, 32'h0);

      // Five wait states with a branch captured mid-REQ
      fetch_start = 1'b1; step(); fetch_start = 1'b0;
      chk("ws_addr", imem_addr, 32'h0);
      step();
      pulse_update(1'b1, 32'h0000_0040);
      fetch_start = 1'b1; step(); fetch_start = 1'b0;
      step(); step();
      chk("ws_req_held", 32'(imem_req), 32'd1);
      chk("ws_addr_held", imem_addr, 32'h0);
      chk("ws_pc_held", pc, 32'h0);
      imem_ack = 1'b1; imem_rdata = 32'h0000_0093; step(); imem_ack = 1'b0;
      chk("ws_pc_new", pc, 32'h40);
      chk("ws_instr", instr, 32'h0000_0093);
      chk("ws_valid", 32'(instr_valid), 32'd1);
      chk("ws_req_done", 32'(imem_req), 32'd0);

      // Update and fetch in the same idle cycle
      pc_update = 1'b1; pc_sel = 1'b1; branch_target = 32'h0000_0080; fetch_start = 1'b1;
      step();
      pc_update = 1'b0; pc_sel = 1'b0; branch_target = '0; fetch_start = 1'b0;
      chk("both_addr", imem_addr, 32'h80);
      chk("both_pc", pc, 32'h80);
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678; step(); imem_ack = 1'b0;
      chk("both_instr", instr, 32'h1234_5678);

      // Timeout after 16 cycles without ack
      fetch_start = 1'b1; step(); fetch_start = 1'b0;
      chk("to_addr", imem_addr, 32'h80);
      for (int i = 0; i < 15; i++) step();
      chk("to_fault_15", 32'(fault), 32'd0);
      chk("to_req_15", 32'(imem_req), 32'd1);
      step();
      chk("to_fault_16", 32'(fault), 32'd1);
      chk("to_req_16", 32'(imem_req), 32'd0);
      chk("to_instr", instr, NOP);
      chk("to_valid", 32'(instr_valid), 32'd0);
      imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D; step(); imem_ack = 1'b0;
      chk("to_ack_ignored", instr, NOP);
      rst = 1'b1; step(); rst = 1'b0;
      chk("to_rst_fault", 32'(fault), 32'd0);
      chk("to_rst_pc", pc, 32'h0);
      chk("to_rst_busy", 32'(busy), 32'd0);

      // Reset mid-REQ, late ack ignored
      fetch_start = 1'b1; step(); fetch_start = 1'b0;
      chk("mr_req", 32'(imem_req), 32'd1);
      rst = 1'b1; step(); rst = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; step(); imem_ack = 1'b0;
      chk("mr_instr", instr, NOP);
      chk("mr_valid", 32'(instr_valid), 32'd0);
      chk("mr_req", 32'(imem_req), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the multicycle control FSM.
- Owns the program counter and the instruction register.
- Issues a single-beat read to instruction memory with a req/ack handshake and holds the fetched word stable for decode and execute.
- Applies PC updates committed by control: sequential, or branch/jump target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max cycles waiting for imem_ack before fault (1..255).
- NOP_WORD, 32'h0000_0013, instruction register value after reset or fault (ADDI x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- fetch_start  in  1  pulse from control fetch state; begin a fetch.
- pc_update  in  1  pulse from control at end of instruction; commit next PC.
- pc_sel  in  1  0: next PC = pc+4; 1: next PC = branch_target.
- branch_target  in  32  branch/jump target address from ALU.
- imem_req  out  1  memory read request, registered.
- imem_addr  out  32  read address, registered; equals pc while imem_req=1.
- imem_rdata  in  32  read data, sampled when imem_ack=1.
- imem_ack  in  1  memory completion, one-cycle pulse.
- instr  out  32  instruction register to control/decode.
- instr_valid  out  1  instr holds the word fetched from the current pc.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, combinational, for JAL/JALR link.
- busy  out  1  high in REQ state.
- fault  out  1  sticky; memory timeout or misaligned target.

Behaviour:
- Reset (rst=1 at clk edge, any state including mid-REQ):
  - pc=RESET_PC, instr=NOP_WORD, instr_valid=0, imem_req=0, imem_addr=RESET_PC.
  - fault=0, pending update cleared, wait counter=0, state=IDLE.
  - A late imem_ack after reset is ignored.
- States: IDLE, REQ, FAULT.
- IDLE:
  - fetch_start=1 → next cycle state=REQ, imem_req=1, imem_addr=pc, instr_valid=0, counter=0.
  - If pc_update is also high in the same cycle, the update is applied first and imem_addr equals the new PC.
- REQ:
  - imem_req and imem_addr are held stable until ack.
  - imem_ack=1 → instr<=imem_rdata, instr_valid<=1, imem_req<=0, state<=IDLE, all on the same edge. Latency from fetch_start to instr_valid is 2 cycles with zero-wait memory.
  - No ack → counter increments. After TIMEOUT cycles without ack: fault<=1, imem_req<=0, instr<=NOP_WORD, instr_valid<=0, state<=FAULT.
  - fetch_start in REQ is ignored.
  - pc_update in REQ is captured into a one-deep pending register (sel and target). It is applied on the edge leaving REQ; pc does not change while imem_req=1. A second pc_update while one is pending overwrites it.
- FAULT: all requests held low. Only rst exits FAULT.
- PC update:
  - pc_sel=0: pc<=pc+4, modulo 2^32 (32'hFFFF_FFFC → 0).
  - pc_sel=1: effective target = branch_target with bit0 cleared (JALR rule).
    - If effective target bit1=1: pc unchanged, fault<=1, state<=FAULT.
    - Otherwise pc<=effective target.
- instr_valid stays high and instr stays unchanged until the next fetch_start or reset.
- An imem_ack outside REQ is ignored.

Decomposition:
- Shared package holds:
  - fetch state encoding (IDLE=2'd0, REQ=2'd1, FAULT=2'd2);
  - NOP_WORD;
  - the PC width constant;
  - the opcode constants already used by control, so decode and fetch share one source.
- One natural sub-module: fetch_next_pc. It is combinational and computes the next PC, the effective target and the misalignment flag from pc, pc_sel and branch_target.
- The FSM, counter and registers stay in fetch_unit.

Test Plan:
- Reset then fetch_start, ack on the cycle after req with imem_rdata=32'h00500093 → imem_addr=0, instr=32'h00500093, instr_valid=1 two cycles after fetch_start, pc=0.
- pc_update pc_sel=0 three times from pc=0; then set pc=32'hFFFF_FFFC and pulse pc_update with pc_sel=0 → pc=12 after the three updates; pc wraps to 0 from 32'hFFFF_FFFC; pc_plus4 tracks pc each step.
- pc_update pc_sel=1, branch_target=32'h0000_0101 → pc=32'h100 and fault=0. Then branch_target=32'h0000_0102 → pc stays 32'h100, fault=1, later fetch_start gives no imem_req.
- Memory with 5 wait states; pc_update pc_sel=1, target=32'h40 issued during REQ → imem_addr stays at the old pc until ack, pc=32'h40 on the ack edge.
- No ack for TIMEOUT=16 cycles → fault=1 on cycle 16, imem_req=0, instr=32'h00000013. Then rst=1 for one cycle → fault=0, pc=RESET_PC.
- rst asserted mid-REQ with ack arriving one cycle later → ack ignored, instr=NOP_WORD, instr_valid=0, state IDLE.
